serial_sub_ctrl: RTL and testbench

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl.sv | 106 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell swept LSB first over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, busy_q, done_q, bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic x, y, bit_d, br_d, last;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    x     = a_q[cnt_q];
    y     = b_q[cnt_q];
    bit_d = x ^ y ^ br_q;
    br_d  = (~x & y) | (~(x ^ y) & br_q);
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operand and partial-result registers are cleared too, keeping reset state fully known.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Partial result shifts in from the top; diff is only loaded once it is complete.
          res_q <= {bit_d, res_q[WIDTH-1:1]};
          br_q  <= br_d;
          if (last) begin
            diff_q  <= {bit_d, res_q[WIDTH-1:1]};
            bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= br_q ^ br_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases, abort, back-to-back
// and randomized operations against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] diff;
  logic         busy, done, bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
  logic         prev_ovf = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [W-1:0] prev_diff = '0;
  logic         prev_bout = 1'b0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                input logic tbin, output logic [W-1:0] d, output logic bo);
    int r;
    r  = int'(ta) - int'(tbv) - int'(tbin);
    d  = W'(r);
    bo = (r < 0);
  endfunction

`ifdef SERIAL_SUB_OVF_EN
  function automatic logic model_ovf(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                     input logic tbin);
    int sa, sb, r;
    sa = ta[W-1]  ? int'(ta)  - (1 << W) : int'(ta);
    sb = tbv[W-1] ? int'(tbv) - (1 << W) : int'(tbv);
    r  = sa - sb - int'(tbin);
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction
`endif

  // One complete operation; glitch selects a cycle (0..W-1 RUN, W = DONE) in which start
  // is re-pulsed with operands ga/gb, which must be ignored.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin,
                        input int glitch, input logic [W-1:0] ga, input logic [W-1:0] gb,
                        input string tag);
    logic [W-1:0] ed;
    logic         eb;
`ifdef SERIAL_SUB_OVF_EN
    logic         eo;
    eo = model_ovf(ta, tbv, tbin);
`endif
    model(ta, tbv, tbin, ed, eb);
    @(negedge clk);
    a = ta; b = tbv; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i <= W; i++) begin
      start = (i == glitch);
      a     = (i == glitch) ? ga : W'($urandom);
      b     = (i == glitch) ? gb : W'($urandom);
      bin   = 1'($urandom);
      if (i < W) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          failures++;
          $display("FAIL %s run_cycle%0d busy/done got=%b exp=10", tag, i, {busy, done});
        end
        checks++;
        if ({diff, bout} !== {prev_diff, prev_bout}) begin
          failures++;
          $display("FAIL %s hold_cycle%0d diff/bout got=%h/%b exp=%h/%b",
                   tag, i, diff, bout, prev_diff, prev_bout);
        end
      end else begin
        checks++;
        if ({busy, done} !== 2'b01) begin
          failures++;
          $display("FAIL %s done_cycle busy/done got=%b exp=01", tag, {busy, done});
        end
        checks++;
        if ({diff, bout} !== {ed, eb}) begin
          failures++;
          $display("FAIL %s result diff/bout got=%h/%b exp=%h/%b", tag, diff, bout, ed, eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== eo) begin
          failures++;
          $display("FAIL %s ovf got=%b exp=%b", tag, ovf, eo);
        end
`endif
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL %s after_done busy/done got=%b exp=00", tag, {busy, done});
    end
    prev_diff = ed;
    prev_bout = eb;
`ifdef SERIAL_SUB_OVF_EN
    prev_ovf  = eo;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 8'hA5; b = 8'h5A; bin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, bout} !== '0) begin
      failures++;
      $display("FAIL reset_state busy/done/diff/bout got=%b/%b/%h/%b exp=0/0/00/0",
               busy, done, diff, bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b exp=0", ovf);
    end
`endif
    rst_n = 1'b1; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL reset_idle busy/done got=%b exp=00", {busy, done});
      end
    end
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03, 1'b0, -1, 8'h00, 8'h00, "d_05_03");
    run_op(8'h03, 8'h05, 1'b0, -1, 8'h00, 8'h00, "d_03_05");
    run_op(8'h00, 8'h00, 1'b1, -1, 8'h00, 8'h00, "d_00_00_bin");
    run_op(8'h80, 8'h01, 1'b0, -1, 8'h00, 8'h00, "d_80_01");
    run_op(8'h7F, 8'hFF, 1'b0, -1, 8'h00, 8'h00, "d_7f_ff");
    run_op(8'hFF, 8'hFF, 1'b1, -1, 8'h00, 8'h00, "d_ff_ff_bin");
  endtask

  task automatic test_ignore_start();
    run_op(8'h10, 8'h01, 1'b0, 2, 8'hFF, 8'hFF, "ign_run");
    run_op(8'h10, 8'h01, 1'b0, W, 8'hFF, 8'hFF, "ign_done");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    checks++;
    if ({busy, done, diff, bout} !== '0) begin
      failures++;
      $display("FAIL abort_state busy/done/diff/bout got=%b/%b/%h/%b exp=0/0/00/0",
               busy, done, diff, bout);
    end
    prev_diff = '0;
    prev_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    prev_ovf  = 1'b0;
`endif
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL abort_quiet cycle%0d busy/done got=%b exp=00", i, {busy, done});
      end
    end
    run_op(8'h09, 8'h04, 1'b0, -1, 8'h00, 8'h00, "after_abort");
  endtask

  task automatic test_back_to_back();
    int cyc, n, last_cyc;
    cyc = 0; n = 0; last_cyc = -1;
    @(negedge clk);
    a = 8'h20; b = 8'h10; bin = 1'b0; start = 1'b1;
    while (n < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) begin
        checks++;
        if ({diff, bout} !== {8'h10, 1'b0}) begin
          failures++;
          $display("FAIL b2b_result%0d diff/bout got=%h/%b exp=10/0", n, diff, bout);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last_cyc != W + 2) begin
            failures++;
            $display("FAIL b2b_spacing%0d got=%0d exp=%0d", n, cyc - last_cyc, W + 2);
          end
        end
        last_cyc = cyc;
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL b2b_count done_pulses got=%0d exp=3 within 60 cycles", n);
    end
    prev_diff = 8'h10;
    prev_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    prev_ovf  = 1'b0;
`endif
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL b2b_stop busy/done got=%b exp=00", {busy, done});
      end
    end
  endtask

  task automatic test_random();
    int glitch;
    for (int k = 0; k < 40; k++) begin
      glitch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), glitch,
             W'($urandom), W'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
